comp_seq: RTL

//  Multi-byte magnitude-compare sequencer for CPU branch/compare ops. Latches two

---
 rtl/comp_seq_pkg.sv | 18 +
 rtl/comp_seq_if.sv | 29 ++
 rtl/comp_8.sv | 22 ++
 rtl/comp_seq.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/comp_seq_pkg.sv
// Shared definitions for the multi-byte compare sequencer and later byte-serial ALU sequencers.
// Holds the state encodings, the byte width and the signed-compare bias helper.
package comp_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Offset-binary trick: flipping the sign bit makes two's-complement order match unsigned order.
    function automatic logic [BYTE_W-1:0] sign_bias(input logic [BYTE_W-1:0] b, input logic en);
        return {b[BYTE_W-1] ^ en, b[BYTE_W-2:0]};
    endfunction

endpackage

// File: rtl/comp_seq_if.sv
// Operand/flag bus between the operand source, the compare sequencer and the flag register.
// The master drives the request and operands; the slave returns status and held flags.
interface comp_seq_if #(
    parameter int NBYTES = 4
) ();
    localparam int W = 8 * NBYTES;

    logic         start;
    logic         signed_op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic         eq;
    logic         gt;
    logic         lt;

    modport master (
        output start, signed_op, a, b,
        input  ready, busy, done, eq, gt, lt
    );

    modport slave (
        input  start, signed_op, a, b,
        output ready, busy, done, eq, gt, lt
    );

endinterface

// File: rtl/comp_8.sv
// One-byte magnitude compare stage with an MSB-first EQ/GT cascade.
// i_eq8/i_gt8 carry the verdict of the more significant bytes; o_eq0/o_gt0 include this byte.
module comp_8 (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_eq8,
    input  logic       i_gt8,
    output logic       o_eq0,
    output logic       o_gt0
);

    logic w_byte_eq;
    logic w_byte_gt;

    assign w_byte_eq = (i_a == i_b);
    assign w_byte_gt = (i_a > i_b);

    // A lower byte only decides the result while all higher bytes are still equal.
    assign o_eq0 = i_eq8 & w_byte_eq;
    assign o_gt0 = i_gt8 | (i_eq8 & w_byte_gt);

endmodule

// File: rtl/comp_seq.sv
// Byte-serial magnitude compare sequencer: latches A/B, streams them MS byte first through one
// comp_8 stage and publishes held EQ/GT/LT flags with a one-cycle done pulse.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | ready for a request; start latches operands
//   ST_RUN  | one byte per clock through comp_8, cascade in eq/gt acc
//   ST_DONE | flags just updated; done pulse for this cycle only
module comp_seq
    import comp_seq_pkg::*;
#(
    parameter int NBYTES     = 4,
    parameter int EARLY_EXIT = 0
) (
    input  logic         clk,
    input  logic         rst,
    comp_seq_if.slave    bus
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int CNT_W = $clog2(NBYTES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);

    state_t             r_state;
    state_t             w_state_nxt;

    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic               r_signed;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_eq_acc;
    logic               r_gt_acc;

    logic               r_ready;
    logic               r_busy;
    logic               r_done;
    logic               r_eq;
    logic               r_gt;
    logic               r_lt;

    logic [BYTE_W-1:0]  w_sel_a;
    logic [BYTE_W-1:0]  w_sel_b;
    logic [BYTE_W-1:0]  w_cmp_a;
    logic [BYTE_W-1:0]  w_cmp_b;
    logic               w_is_ms;
    logic               w_eq0;
    logic               w_gt0;
    logic               w_last;

    // Byte select straight off the latched operands: cnt 0 picks the MS byte.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (r_cnt == CNT_W'(NBYTES - 1 - i)) begin
                w_sel_a = r_a[i*BYTE_W +: BYTE_W];
                w_sel_b = r_b[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign w_is_ms = (r_cnt == '0);
    assign w_cmp_a = sign_bias(w_sel_a, r_signed & w_is_ms);
    assign w_cmp_b = sign_bias(w_sel_b, r_signed & w_is_ms);

    comp_8 u_comp_8 (
        .i_a   (w_cmp_a),
        .i_b   (w_cmp_b),
        .i_eq8 (r_eq_acc),
        .i_gt8 (r_gt_acc),
        .o_eq0 (w_eq0),
        .o_gt0 (w_gt0)
    );

    assign w_last = (r_cnt == CNT_LAST) || ((EARLY_EXIT != 0) && !w_eq0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == ST_IDLE);
            r_busy  <= (w_state_nxt == ST_RUN);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE:                w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_cnt    <= '0;
            r_eq_acc <= 1'b1;
            r_gt_acc <= 1'b0;
            r_eq     <= 1'b0;
            r_gt     <= 1'b0;
            r_lt     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_a      <= bus.a;
                        r_b      <= bus.b;
                        r_signed <= bus.signed_op;
                        r_cnt    <= '0;
                        r_eq_acc <= 1'b1;
                        r_gt_acc <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_eq_acc <= w_eq0;
                    r_gt_acc <= w_gt0;
                    if (w_last) begin
                        r_eq <= w_eq0;
                        r_gt <= w_gt0;
                        r_lt <= ~w_eq0 & ~w_gt0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready = r_ready;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.eq    = r_eq;
    assign bus.gt    = r_gt;
    assign bus.lt    = r_lt;

endmodule
